// File: rtl/multi_sin_scroller.sv
// Multi-channel scrolling sine-trace renderer.
// Each channel owns a phase register that advances by 'speed' on every
// enabled frame_start; per pixel, every channel looks up a sine table
// indexed by the column step plus its phase and reports a hit when the
// pixel row lies inside its THICK-row trace. The result is registered.
// Optional feature macro: MULTI_SIN_SCROLLER_REVERSE_EN. When defined,
// odd-index channels scroll backwards by decrementing their phase.
module multi_sin_scroller #(
  parameter int CHANNELS  = 2,
  parameter int LUT_LOG2  = 4,
  parameter int TOP_Y     = 180,
  parameter int CH_PITCH  = 80,
  parameter int BAR_SHIFT = 5,
  parameter int AMP_SHIFT = 2,
  parameter int THICK     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_start,
  input  logic       enable,
  input  logic [3:0] speed,
  input  logic       pix_valid,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  output logic       draw,
  output logic [1:0] ch_hit
);

  // Master 64-entry table floor(128 + 127*sin(2*pi*k/64)); shallower
  // tables are exact subsamples of it, so one table serves every depth.
  function automatic logic [7:0] sine64(input logic [5:0] k);
    logic [7:0] v;
    case (k)
      6'd0:  v = 8'd128;  6'd1:  v = 8'd140;  6'd2:  v = 8'd152;  6'd3:  v = 8'd164;
      6'd4:  v = 8'd176;  6'd5:  v = 8'd187;  6'd6:  v = 8'd198;  6'd7:  v = 8'd208;
      6'd8:  v = 8'd217;  6'd9:  v = 8'd226;  6'd10: v = 8'd233;  6'd11: v = 8'd240;
      6'd12: v = 8'd245;  6'd13: v = 8'd249;  6'd14: v = 8'd252;  6'd15: v = 8'd254;
      6'd16: v = 8'd255;  6'd17: v = 8'd254;  6'd18: v = 8'd252;  6'd19: v = 8'd249;
      6'd20: v = 8'd245;  6'd21: v = 8'd240;  6'd22: v = 8'd233;  6'd23: v = 8'd226;
      6'd24: v = 8'd217;  6'd25: v = 8'd208;  6'd26: v = 8'd198;  6'd27: v = 8'd187;
      6'd28: v = 8'd176;  6'd29: v = 8'd164;  6'd30: v = 8'd152;  6'd31: v = 8'd140;
      6'd32: v = 8'd128;  6'd33: v = 8'd115;  6'd34: v = 8'd103;  6'd35: v = 8'd91;
      6'd36: v = 8'd79;   6'd37: v = 8'd68;   6'd38: v = 8'd57;   6'd39: v = 8'd47;
      6'd40: v = 8'd38;   6'd41: v = 8'd29;   6'd42: v = 8'd22;   6'd43: v = 8'd15;
      6'd44: v = 8'd10;   6'd45: v = 8'd6;    6'd46: v = 8'd3;    6'd47: v = 8'd1;
      6'd48: v = 8'd1;    6'd49: v = 8'd1;    6'd50: v = 8'd3;    6'd51: v = 8'd6;
      6'd52: v = 8'd10;   6'd53: v = 8'd15;   6'd54: v = 8'd22;   6'd55: v = 8'd29;
      6'd56: v = 8'd38;   6'd57: v = 8'd47;   6'd58: v = 8'd57;   6'd59: v = 8'd68;
      6'd60: v = 8'd79;   6'd61: v = 8'd91;   6'd62: v = 8'd103;  default: v = 8'd115;
    endcase
    return v;
  endfunction

  // Scale a LUT_LOG2-bit index onto the 64-entry master table.
  function automatic logic [7:0] lut_value(input logic [LUT_LOG2-1:0] idx);
    logic [5:0] k;
    k = 6'(idx) << (6 - LUT_LOG2);
    return sine64(k);
  endfunction

  logic [LUT_LOG2-1:0] step;
  logic [LUT_LOG2-1:0] col_step;
  logic [CHANNELS-1:0] hit;
  logic                any_hit;
  logic [1:0]          first_ch;

  // Both the phase step and the column step wrap naturally modulo D.
  assign step     = LUT_LOG2'(speed);
  assign col_step = LUT_LOG2'(pix_x >> BAR_SHIFT);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam logic [10:0] BASE = 11'(TOP_Y + c * CH_PITCH);

    logic [LUT_LOG2-1:0] phase;
    logic [LUT_LOG2-1:0] next_phase;
    logic [LUT_LOG2-1:0] idx;
    logic [10:0]         wave;
    logic [11:0]         wave_end;

`ifdef MULTI_SIN_SCROLLER_REVERSE_EN
    if ((c % 2) == 1) begin : g_rev
      assign next_phase = phase - step;
    end else begin : g_fwd
      assign next_phase = phase + step;
    end
`else
    assign next_phase = phase + step;
`endif

    // Phase register: reset wins over frame_start; enable=0 freezes it.
    always_ff @(posedge clk) begin
      if (rst) begin
        phase <= '0;
      end else if (frame_start && enable) begin
        phase <= next_phase;
      end
    end

    // Rendering always reads the current (pre-update) phase.
    assign idx      = col_step + phase;
    assign wave     = BASE + 11'(lut_value(idx) >> AMP_SHIFT);
    assign wave_end = {1'b0, wave} + 12'(THICK);
    assign hit[c]   = pix_valid && ({1'b0, pix_y} >= wave) &&
                      ({2'b0, pix_y} < wave_end);
  end

  // Lowest-index hitting channel wins; index stays 0 when nothing hits.
  always_comb begin
    any_hit  = 1'b0;
    first_ch = 2'd0;
    for (int c = CHANNELS - 1; c >= 0; c--) begin
      if (hit[c]) begin
        any_hit  = 1'b1;
        first_ch = 2'(c);
      end
    end
  end

  // Output register giving the one-cycle pixel latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      draw   <= 1'b0;
      ch_hit <= 2'd0;
    end else begin
      draw   <= any_hit;
      ch_hit <= any_hit ? first_ch : 2'd0;
    end
  end

endmodule

// File: tb/tb_multi_sin_scroller.sv
// Self-checking bench for multi_sin_scroller at default parameters.
// A behavioural model computes each expected {draw, ch_hit} when the
// pixel is driven and pushes it to a queue; it is popped after the edge.
module tb_multi_sin_scroller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_start = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] speed = 4'd0;
  logic       pix_valid = 1'b0;
  logic [9:0] pix_x = 10'd0;
  logic [9:0] pix_y = 10'd0;
  logic       draw;
  logic [1:0] ch_hit;

  int         vectors = 0;
  int         miscompares = 0;
  int         lut [16];
  int         ph [2];
  logic [2:0] exp_q [$];
  logic [2:0] expv;
  logic       pre_draw;

  multi_sin_scroller dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .enable(enable),
    .speed(speed), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .draw(draw), .ch_hit(ch_hit)
  );

  // 10-time-unit clock.
  always #5 clk = ~clk;

  // Expected registered output for a pixel under the current model phases.
  function automatic logic [2:0] model_out(input bit v, input int x, input int y);
    logic [2:0] r;
    r = 3'b000;
    if (v) begin
      for (int c = 1; c >= 0; c--) begin
        int idx;
        int wave;
        idx  = ((x >> 5) + ph[c]) % 16;
        wave = 180 + c * 80 + (lut[idx] >> 2);
        if (y >= wave && y < wave + 4) r = {1'b1, 2'(c)};
      end
    end
    return r;
  endfunction

  // Drive one cycle of stimulus, record expectation, then update the model.
  task automatic drive(input bit r, input bit fs, input bit en, input int spd,
                       input bit v, input int x, input int y);
    @(negedge clk);
    rst = r; frame_start = fs; enable = en; speed = 4'(spd);
    pix_valid = v; pix_x = 10'(x); pix_y = 10'(y);
    exp_q.push_back(r ? 3'b000 : model_out(v, x, y));
    if (r) begin
      ph[0] = 0; ph[1] = 0;
    end else if (fs && en) begin
      ph[0] = (ph[0] + spd) % 16;
`ifdef MULTI_SIN_SCROLLER_REVERSE_EN
      ph[1] = ((ph[1] - spd) % 16 + 16) % 16;
`else
      ph[1] = (ph[1] + spd) % 16;
`endif
    end
    #1 pre_draw = draw;
    @(posedge clk);
    #1;
    rst = 1'b0; frame_start = 1'b0;
  endtask

  task automatic test_reset();
    int ys [5] = '{212, 215, 211, 216, 212};
    bit vs [5] = '{1, 1, 1, 1, 0};
    drive(1, 1, 1, 7, 1, 0, 212);
    drive(1, 0, 0, 0, 0, 0, 0);
    expv = exp_q.pop_front(); vectors++;
    if ({draw, ch_hit} !== expv) begin
      miscompares++;
      $display("[TB] FAIL reset_state: draw=%0b ch_hit=%0d, expected draw=%0b ch_hit=%0d", draw, ch_hit, expv[2], expv[1:0]);
    end
    void'(exp_q.pop_front());
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, 0, 0, vs[i], 0, ys[i]);
      expv = exp_q.pop_front(); vectors++;
      if ({draw, ch_hit} !== expv) begin
        miscompares++;
        $display("[TB] FAIL reset_ch0 y=%0d v=%0b: draw=%0b ch_hit=%0d, expected draw=%0b ch_hit=%0d", ys[i], vs[i], draw, ch_hit, expv[2], expv[1:0]);
      end
    end
  endtask

  task automatic test_channel1();
    drive(0, 0, 0, 0, 1, 0, 300);
    expv = exp_q.pop_front(); vectors++;
    if ({draw, ch_hit} !== expv) begin
      miscompares++;
      $display("[TB] FAIL ch1_miss: draw=%0b ch_hit=%0d, expected draw=%0b ch_hit=%0d", draw, ch_hit, expv[2], expv[1:0]);
    end
    drive(0, 0, 0, 0, 1, 0, 292);
    vectors++;
    if (pre_draw !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL ch1_latency: draw before edge=%0b, expected 0", pre_draw);
    end
    expv = exp_q.pop_front(); vectors++;
    if ({draw, ch_hit} !== expv) begin
      miscompares++;
      $display("[TB] FAIL ch1_hit: draw=%0b ch_hit=%0d, expected draw=%0b ch_hit=%0d", draw, ch_hit, expv[2], expv[1:0]);
    end
  endtask

  task automatic test_phase_advance();
    int ys [3] = '{243, 212, 246};
    drive(0, 1, 1, 4, 0, 0, 0);
    void'(exp_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 0, ys[i]);
      expv = exp_q.pop_front(); vectors++;
      if ({draw, ch_hit} !== expv) begin
        miscompares++;
        $display("[TB] FAIL advance y=%0d: draw=%0b ch_hit=%0d, expected draw=%0b ch_hit=%0d", ys[i], draw, ch_hit, expv[2], expv[1:0]);
      end
    end
    for (int x = 0; x < 640; x += 64) begin
      drive(0, 0, 0, 0, 1, x, 243);
      expv = exp_q.pop_front(); vectors++;
      if ({draw, ch_hit} !== expv) begin
        miscompares++;
        $display("[TB] FAIL advance_sweep x=%0d: draw=%0b ch_hit=%0d, expected draw=%0b ch_hit=%0d", x, draw, ch_hit, expv[2], expv[1:0]);
      end
    end
  endtask

  task automatic test_wrap_freeze();
    int ys [3] = '{189, 188, 192};
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 15, 0, 0, 0);
    drive(0, 1, 1, 15, 0, 0, 0);
    repeat (3) void'(exp_q.pop_front());
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 3; i++) begin
        drive(0, 0, 0, 0, 1, 0, ys[i]);
        expv = exp_q.pop_front(); vectors++;
        if ({draw, ch_hit} !== expv) begin
          miscompares++;
          $display("[TB] FAIL wrap_freeze pass=%0d y=%0d: draw=%0b ch_hit=%0d, expected draw=%0b ch_hit=%0d", pass, ys[i], draw, ch_hit, expv[2], expv[1:0]);
        end
      end
      drive(0, 1, 0, 15, 0, 0, 0);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_same_cycle();
    drive(0, 1, 1, 1, 1, 0, 189);
    expv = exp_q.pop_front(); vectors++;
    if ({draw, ch_hit} !== expv) begin
      miscompares++;
      $display("[TB] FAIL same_cycle_pre: draw=%0b ch_hit=%0d, expected draw=%0b ch_hit=%0d", draw, ch_hit, expv[2], expv[1:0]);
    end
    drive(0, 0, 0, 0, 1, 0, 199);
    expv = exp_q.pop_front(); vectors++;
    if ({draw, ch_hit} !== expv) begin
      miscompares++;
      $display("[TB] FAIL same_cycle_post: draw=%0b ch_hit=%0d, expected draw=%0b ch_hit=%0d", draw, ch_hit, expv[2], expv[1:0]);
    end
  endtask

  task automatic test_reverse_reset();
    int ys [4] = '{260, 323, 212, 292};
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 4, 0, 0, 0);
    repeat (2) void'(exp_q.pop_front());
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 1, 0, ys[i]);
      expv = exp_q.pop_front(); vectors++;
      if ({draw, ch_hit} !== expv) begin
        miscompares++;
        $display("[TB] FAIL reverse y=%0d: draw=%0b ch_hit=%0d, expected draw=%0b ch_hit=%0d", ys[i], draw, ch_hit, expv[2], expv[1:0]);
      end
    end
    drive(1, 1, 1, 4, 1, 0, 243);
    expv = exp_q.pop_front(); vectors++;
    if ({draw, ch_hit} !== expv) begin
      miscompares++;
      $display("[TB] FAIL reset_priority: draw=%0b ch_hit=%0d, expected draw=%0b ch_hit=%0d", draw, ch_hit, expv[2], expv[1:0]);
    end
    for (int i = 2; i < 4; i++) begin
      drive(0, 0, 0, 0, 1, 0, ys[i]);
      expv = exp_q.pop_front(); vectors++;
      if ({draw, ch_hit} !== expv) begin
        miscompares++;
        $display("[TB] FAIL after_reset y=%0d: draw=%0b ch_hit=%0d, expected draw=%0b ch_hit=%0d", ys[i], draw, ch_hit, expv[2], expv[1:0]);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      bit fs;
      bit en;
      bit v;
      int x;
      int y;
      fs = ($urandom_range(0, 5) == 0);
      en = 1'($urandom_range(0, 1));
      v  = ($urandom_range(0, 3) != 0);
      x  = $urandom_range(0, 639);
      y  = $urandom_range(180, 330);
      drive(0, fs, en, $urandom_range(0, 15), v, x, y);
      expv = exp_q.pop_front(); vectors++;
      if ({draw, ch_hit} !== expv) begin
        miscompares++;
        $display("[TB] FAIL back_to_back #%0d x=%0d y=%0d: draw=%0b ch_hit=%0d, expected draw=%0b ch_hit=%0d", i, x, y, draw, ch_hit, expv[2], expv[1:0]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      lut[i] = $rtoi($floor(128.0 + 127.0 * $sin(2.0 * 3.141592653589793 * i / 16.0)));
    ph[0] = 0; ph[1] = 0;
    test_reset();
    test_channel1();
    test_phase_advance();
    test_wrap_freeze();
    test_same_cycle();
    test_reverse_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
